uart_tx_feeder: RTL and testbench

Transmit-side buffer and launcher for the UART. Accepts bytes from the host into a small synchronous FIFO and pops them one at a time into a held data register. For each byte it raises `transmit` toward the TX bit-level FSM and waits for that transmitter to finish before launching the next. It sits directly upstream of the TX FSM and shift register, supplying both the byte to load and the request that starts a frame.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_tx_feeder.sv | 77 +++++++
 tb/tb_uart_tx_feeder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared feeder state encoding and default sizing for the UART transmit path
package uart_pkg;

  localparam int DEFAULT_WORD_LENGTH = 8;
  localparam int DEFAULT_DEPTH       = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock byte FIFO with occupancy count and sticky overflow flag
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WORD_LENGTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_accept;
  logic              rd_accept;

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // count is the only occupancy state; full/empty decode straight from that register
  assign full    = (count == (ADDR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers host bytes and launches one TX frame at a time toward the bit-level FSM
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WORD_LENGTH-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  input  logic                   tx_busy,
  output logic                   transmit,
  output logic [WORD_LENGTH-1:0] tx_data
);

  feeder_state_t          state;
  feeder_state_t          state_next;
  logic                   pop;
  logic [WORD_LENGTH-1:0] head_data;

  sync_fifo #(
    .WIDTH  (WORD_LENGTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      transmit <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_next;
      transmit <= (state_next == ISSUE);
      if (pop) tx_data <= head_data;
    end
  end

  // tx_data only reloads from IDLE, so it is frozen for the whole ISSUE/WAIT_DONE span
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (tx_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder with a queue-based reference model
module tb_uart_tx_feeder;

  localparam int WL         = 8;
  localparam int DEPTH      = 8;
  localparam int AW         = 3;
  localparam int BUSY_LEN   = 160;
  localparam int BUSY_DELAY = 2;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          wr_en   = 1'b0;
  logic [WL-1:0] wr_data = '0;
  logic          tx_busy = 1'b0;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          transmit;
  logic [WL-1:0] tx_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .WORD_LENGTH (WL),
    .DEPTH       (DEPTH),
    .ADDR_W      (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .transmit (transmit),
    .tx_data  (tx_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte queue plus the lifecycle of the frame currently handed to the transmitter
  logic [WL-1:0] mq[$];
  logic          m_ovf      = 1'b0;
  logic          m_tx       = 1'b0;
  logic          m_inflight = 1'b0;
  logic          m_seen     = 1'b0;
  logic [WL-1:0] m_data     = '0;

  always @(posedge clk or posedge reset) begin : model
    int pre_size;
    bit launch;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0; m_tx = 1'b0; m_inflight = 1'b0; m_seen = 1'b0; m_data = '0;
    end else begin
      pre_size = mq.size();
      launch   = !m_inflight && (pre_size > 0);
      if (launch) begin
        m_data = mq.pop_front();
        m_inflight = 1'b1; m_tx = 1'b1; m_seen = 1'b0;
      end else if (m_inflight && !m_seen && tx_busy) begin
        m_tx = 1'b0; m_seen = 1'b1;
      end else if (m_inflight && m_seen && !tx_busy) begin
        m_inflight = 1'b0;
      end
      if (wr_en) begin
        if (pre_size == DEPTH) m_ovf = 1'b1;
        else mq.push_back(wr_data);
      end
    end
  end

  logic [WL-1:0] emitted[$];
  logic          prev_tx = 1'b0;

  always @(negedge clk) begin
    check("count",    32'(count),    32'(mq.size()));
    check("full",     32'(full),     32'(mq.size() == DEPTH));
    check("empty",    32'(empty),    32'(mq.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("transmit", 32'(transmit), 32'(m_tx));
    check("tx_data",  32'(tx_data),  32'(m_data));
    if (transmit && !prev_tx) emitted.push_back(tx_data);
    prev_tx = transmit;
  end

  // Transmitter stand-in: busy BUSY_DELAY cycles after a request, held for BUSY_LEN cycles
  int d_cnt = 0;
  int h_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      tx_busy = 1'b0; d_cnt = 0; h_cnt = 0;
    end else if (h_cnt > 0) begin
      h_cnt--;
      if (h_cnt == 0) tx_busy = 1'b0;
    end else if (d_cnt > 0) begin
      d_cnt--;
      if (d_cnt == 0) begin tx_busy = 1'b1; h_cnt = BUSY_LEN; end
    end else if (transmit && !tx_busy) begin
      d_cnt = BUSY_DELAY;
    end
  end

  task automatic put(input logic [WL-1:0] b);
    wr_en = 1'b1; wr_data = b;
    @(posedge clk); #2;
  endtask

  task automatic wait_transmit_low(input string name);
    int k = 0;
    while (transmit === 1'b1 && k < 100) begin @(posedge clk); #2; k++; end
    check(name, 32'(k < 100), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    int k;
    int n_before;
    repeat (3) @(posedge clk); #2 reset = 1'b0;
    repeat (20) @(posedge clk); #2;
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_count", 32'(count), 32'd0);
    check("idle_transmit", 32'(transmit), 32'd0);
    check("idle_tx_data", 32'(tx_data), 32'd0);

    put(8'hA5); wr_en = 1'b0;
    @(negedge clk);
    check("a5_not_empty", 32'(empty), 32'd0);
    check("a5_no_launch_yet", 32'(transmit), 32'd0);
    @(negedge clk);
    check("a5_transmit", 32'(transmit), 32'd1);
    check("a5_data", 32'(tx_data), 32'hA5);
    check("a5_empty_after_pop", 32'(empty), 32'd1);
    hi = 1;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (transmit) hi++; end
    check("a5_transmit_cycles", 32'(hi), 32'd3);
    check("a5_frames", 32'(emitted.size()), 32'd1);
    @(posedge clk); #2;

    for (int b = 1; b <= 9; b++) put(8'(b));
    put(8'hFF); wr_en = 1'b0;
    @(negedge clk);
    check("burst_full", 32'(full), 32'd1);
    check("burst_count", 32'(count), 32'd8);
    check("burst_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 3000 && emitted.size() < 10; i++) @(posedge clk);
    repeat (200) @(posedge clk); #2;
    check("drain_frames", 32'(emitted.size()), 32'd10);
    for (int i = 1; i <= 9; i++)
      check($sformatf("order_%0d", i), 32'(emitted[i]), 32'(i));
    check("overflow_sticky", 32'(overflow), 32'd1);

    reset = 1'b1; @(posedge clk); #2 reset = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    put(8'h10); put(8'h11); put(8'h12); put(8'h13); wr_en = 1'b0;
    wait_transmit_low("issue_ends_1");
    k = 0;
    while (tx_busy === 1'b1 && k < 400) begin @(posedge clk); #2; k++; end
    check("busy_ends", 32'(k < 400), 32'd1);
    @(posedge clk); #2;
    put(8'h14); wr_en = 1'b0;
    @(negedge clk);
    check("same_edge_count", 32'(count), 32'd3);
    check("same_edge_transmit", 32'(transmit), 32'd1);
    check("same_edge_data", 32'(tx_data), 32'h11);
    check("same_edge_overflow", 32'(overflow), 32'd0);

    @(posedge clk); #2;
    wait_transmit_low("issue_ends_2");
    n_before = emitted.size();
    reset = 1'b1; #1;
    check("rst_transmit", 32'(transmit), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    @(posedge clk); @(posedge clk); #2 reset = 1'b0;
    repeat (30) @(posedge clk); #2;
    check("post_rst_transmit", 32'(transmit), 32'd0);
    check("post_rst_frames", 32'(emitted.size()), 32'(n_before));

    put(8'h5A); wr_en = 1'b0;
    @(negedge clk); @(negedge clk);
    check("relaunch_transmit", 32'(transmit), 32'd1);
    check("relaunch_data", 32'(tx_data), 32'h5A);
    repeat (200) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
